// File: rtl/regfile_alu_unit.sv
// 32x32 register file with two combinational read ports and one write port,
// feeding a single-cycle ALU through an immediate/register operand mux.
module regfile_alu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  reg_R_addr_A,
    input  logic [4:0]  reg_R_addr_B,
    input  logic [4:0]  reg_W_addr,
    input  logic [31:0] wdata,
    input  logic        reg_we,
    input  logic        alu_src_sel,
    input  logic [31:0] imm,
    input  logic [4:0]  shamt,
    input  logic [3:0]  ALU_operation,
    output logic [31:0] rdata_A,
    output logic [31:0] rdata_B,
    output logic [31:0] res,
    output logic        zero,
    output logic        overflow
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLLV = 4'b1010;
    localparam logic [3:0] OP_SRLV = 4'b1011;
    localparam logic [3:0] OP_SRAV = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1101;
    localparam logic [3:0] OP_LUI  = 4'b1110;

    logic [31:0] regs [0:31];
    logic [31:0] a_op;
    logic [31:0] b_op;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  var_sh;

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (reg_we && (reg_W_addr != 5'd0)) begin
            regs[reg_W_addr] <= wdata;
        end
    end

    assign rdata_A = (reg_R_addr_A == 5'd0) ? 32'h0 : regs[reg_R_addr_A];
    assign rdata_B = (reg_R_addr_B == 5'd0) ? 32'h0 : regs[reg_R_addr_B];

    assign a_op   = rdata_A;
    assign b_op   = alu_src_sel ? imm : rdata_B;
    assign sum    = a_op + b_op;
    assign diff   = a_op - b_op;
    assign var_sh = a_op[4:0];

    // SLT uses a true signed compare so it stays correct when A-B overflows.
    always_comb begin
        res      = 32'h0;
        overflow = 1'b0;
        case (ALU_operation)
            OP_AND:  res = a_op & b_op;
            OP_OR:   res = a_op | b_op;
            OP_ADD: begin
                res      = sum;
                overflow = (a_op[31] == b_op[31]) && (sum[31] != a_op[31]);
            end
            OP_XOR:  res = a_op ^ b_op;
            OP_NOR:  res = ~(a_op | b_op);
            OP_SRL:  res = b_op >> shamt;
            OP_SUB: begin
                res      = diff;
                overflow = (a_op[31] != b_op[31]) && (diff[31] != a_op[31]);
            end
            OP_SLT:  res = {31'h0, ($signed(a_op) < $signed(b_op))};
            OP_SLL:  res = b_op << shamt;
            OP_SRA:  res = $unsigned($signed(b_op) >>> shamt);
            OP_SLLV: res = b_op << var_sh;
            OP_SRLV: res = b_op >> var_sh;
            OP_SRAV: res = $unsigned($signed(b_op) >>> var_sh);
            OP_SLTU: res = {31'h0, (a_op < b_op)};
            OP_LUI:  res = b_op << 16;
            default: res = 32'h0;
        endcase
    end

    assign zero = (res == 32'h0);

endmodule

// File: tb/tb_regfile_alu_unit.sv
// Directed self-checking bench for regfile_alu_unit: register file behaviour,
// ALU codes and flags, reset clearing and same-cycle read/write ordering.
module tb_regfile_alu_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  reg_R_addr_A;
    logic [4:0]  reg_R_addr_B;
    logic [4:0]  reg_W_addr;
    logic [31:0] wdata;
    logic        reg_we;
    logic        alu_src_sel;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [3:0]  ALU_operation;
    logic [31:0] rdata_A;
    logic [31:0] rdata_B;
    logic [31:0] res;
    logic        zero;
    logic        overflow;

    int checks;
    int errors;

    regfile_alu_unit dut (
        .clk(clk),
        .rst(rst),
        .reg_R_addr_A(reg_R_addr_A),
        .reg_R_addr_B(reg_R_addr_B),
        .reg_W_addr(reg_W_addr),
        .wdata(wdata),
        .reg_we(reg_we),
        .alu_src_sel(alu_src_sel),
        .imm(imm),
        .shamt(shamt),
        .ALU_operation(ALU_operation),
        .rdata_A(rdata_A),
        .rdata_B(rdata_B),
        .res(res),
        .zero(zero),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] a_addr, input logic [4:0] b_addr,
                                 input logic sel, input logic [31:0] imm_v,
                                 input logic [4:0] sh, input logic [3:0] op);
        reg_R_addr_A  = a_addr;
        reg_R_addr_B  = b_addr;
        alu_src_sel   = sel;
        imm           = imm_v;
        shamt         = sh;
        ALU_operation = op;
        #1;
    endtask

    task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        reg_W_addr = addr;
        wdata      = data;
        reg_we     = 1'b1;
        @(posedge clk);
        #1;
        reg_we = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        reg_R_addr_A = 5'd0; reg_R_addr_B = 5'd0; reg_W_addr = 5'd0;
        wdata = 32'h0; reg_we = 1'b0; alu_src_sel = 1'b0;
        imm = 32'h0; shamt = 5'd0; ALU_operation = 4'b0010;

        // Reset state
        @(negedge clk);
        applyStimulus(5'd3, 5'd4, 1'b0, 32'h0, 5'd0, 4'b0010);
        checkOutput("reset_rdata_A", rdata_A, 32'h0);
        checkOutput("reset_rdata_B", rdata_B, 32'h0);
        checkOutput("reset_res", res, 32'h0);
        checkOutput("reset_zero", {31'h0, zero}, 32'h1);
        checkOutput("reset_overflow", {31'h0, overflow}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Basic writes, r0 stays zero
        writeReg(5'd5, 32'h12345678);
        applyStimulus(5'd5, 5'd0, 1'b0, 32'h0, 5'd0, 4'b0010);
        checkOutput("r5_read", rdata_A, 32'h12345678);
        writeReg(5'd0, 32'hFFFFFFFF);
        applyStimulus(5'd0, 5'd0, 1'b0, 32'h0, 5'd0, 4'b0010);
        checkOutput("r0_read", rdata_A, 32'h0);

        // ADD overflow, SUB to zero
        writeReg(5'd1, 32'h7FFFFFFF);
        writeReg(5'd2, 32'h00000001);
        applyStimulus(5'd1, 5'd2, 1'b0, 32'h0, 5'd0, 4'b0010);
        checkOutput("add_res", res, 32'h80000000);
        checkOutput("add_ovf", {31'h0, overflow}, 32'h1);
        checkOutput("add_zero", {31'h0, zero}, 32'h0);
        applyStimulus(5'd2, 5'd2, 1'b0, 32'h0, 5'd0, 4'b0110);
        checkOutput("sub_res", res, 32'h0);
        checkOutput("sub_zero", {31'h0, zero}, 32'h1);
        checkOutput("sub_ovf", {31'h0, overflow}, 32'h0);

        // Signed/unsigned compares with immediate operand
        writeReg(5'd1, 32'h80000000);
        applyStimulus(5'd1, 5'd0, 1'b1, 32'h1, 5'd0, 4'b0111);
        checkOutput("slt_res", res, 32'h1);
        checkOutput("slt_ovf", {31'h0, overflow}, 32'h0);
        applyStimulus(5'd1, 5'd0, 1'b1, 32'h1, 5'd0, 4'b1101);
        checkOutput("sltu_res", res, 32'h0);
        checkOutput("sltu_zero", {31'h0, zero}, 32'h1);
        applyStimulus(5'd1, 5'd0, 1'b1, 32'h1, 5'd0, 4'b0110);
        checkOutput("sub_imm_res", res, 32'h7FFFFFFF);
        checkOutput("sub_imm_ovf", {31'h0, overflow}, 32'h1);

        // Shifts and LUI
        writeReg(5'd2, 32'h80000010);
        applyStimulus(5'd0, 5'd2, 1'b0, 32'h0, 5'd4, 4'b0101);
        checkOutput("srl_res", res, 32'h08000001);
        applyStimulus(5'd0, 5'd2, 1'b0, 32'h0, 5'd4, 4'b1001);
        checkOutput("sra_res", res, 32'hF8000001);
        applyStimulus(5'd0, 5'd2, 1'b0, 32'h0, 5'd4, 4'b1000);
        checkOutput("sll_res", res, 32'h00000100);
        applyStimulus(5'd0, 5'd2, 1'b0, 32'h0, 5'd0, 4'b0101);
        checkOutput("srl_zero_shamt", res, 32'h80000010);
        applyStimulus(5'd0, 5'd0, 1'b1, 32'h0000ABCD, 5'd0, 4'b1110);
        checkOutput("lui_res", res, 32'hABCD0000);

        // Logic ops, variable shifts using only A[4:0], constant-zero code
        applyStimulus(5'd5, 5'd0, 1'b1, 32'h0000FFFF, 5'd0, 4'b0000);
        checkOutput("and_res", res, 32'h00005678);
        applyStimulus(5'd5, 5'd0, 1'b1, 32'h0, 5'd0, 4'b0100);
        checkOutput("nor_res", res, 32'hEDCBA987);
        applyStimulus(5'd5, 5'd0, 1'b1, 32'hFF00FF00, 5'd0, 4'b0011);
        checkOutput("xor_res", res, 32'hED34A978);
        writeReg(5'd4, 32'h00000024);
        applyStimulus(5'd4, 5'd0, 1'b1, 32'h00000001, 5'd0, 4'b1010);
        checkOutput("sllv_res", res, 32'h00000010);
        applyStimulus(5'd4, 5'd2, 1'b0, 32'h0, 5'd0, 4'b1100);
        checkOutput("srav_res", res, 32'hF8000001);
        applyStimulus(5'd4, 5'd2, 1'b0, 32'h0, 5'd0, 4'b1011);
        checkOutput("srlv_res", res, 32'h08000001);
        applyStimulus(5'd5, 5'd2, 1'b0, 32'h0, 5'd0, 4'b1111);
        checkOutput("op_f_res", res, 32'h0);
        checkOutput("op_f_zero", {31'h0, zero}, 32'h1);

        // Same-cycle write and read of r7: old value before edge, new after
        @(negedge clk);
        applyStimulus(5'd7, 5'd7, 1'b0, 32'h0, 5'd0, 4'b0001);
        reg_W_addr = 5'd7;
        wdata      = 32'hA5A5A5A5;
        reg_we     = 1'b1;
        #1;
        checkOutput("r7_before_edge", rdata_A, 32'h0);
        @(posedge clk);
        #1;
        reg_we = 1'b0;
        checkOutput("r7_after_edge", rdata_A, 32'hA5A5A5A5);
        checkOutput("r7_or_res", res, 32'hA5A5A5A5);

        // Fill r3..r31, then asynchronous reset between edges
        for (int i = 3; i < 32; i++) begin
            writeReg(5'(i), 32'h10000000 | 32'(i));
        end
        applyStimulus(5'd31, 5'd3, 1'b0, 32'h0, 5'd0, 4'b0010);
        checkOutput("r31_loaded", rdata_A, 32'h1000001F);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("r31_async_clear", rdata_A, 32'h0);
        reg_W_addr = 5'd9;
        wdata      = 32'hDEADBEEF;
        reg_we     = 1'b1;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(5'(i), 5'(31 - i), 1'b0, 32'h0, 5'd0, 4'b0010);
            checkOutput("rst_read_A", rdata_A, 32'h0);
            checkOutput("rst_read_B", rdata_B, 32'h0);
        end
        @(negedge clk);
        reg_we = 1'b0;
        rst    = 1'b0;
        applyStimulus(5'd9, 5'd0, 1'b0, 32'h0, 5'd0, 4'b0010);
        checkOutput("r9_write_blocked", rdata_A, 32'h0);
        checkOutput("post_rst_zero", {31'h0, zero}, 32'h1);
        writeReg(5'd9, 32'hCAFEF00D);
        checkOutput("r9_write_resumed", rdata_A, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_alu_unit.md
REGFILE_ALU_UNIT -- requirements
Module: regfile_alu_unit

Interface
Parameters: none; all widths fixed.
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port reg_R_addr_A  input  5  read address, port A.
REQ-004 SHALL have port reg_R_addr_B  input  5  read address, port B.
REQ-005 SHALL have port reg_W_addr  input  5  write address.
REQ-006 SHALL have port wdata  input  32  write data.
REQ-007 SHALL have port reg_we  input  1  write enable.
REQ-008 SHALL have port alu_src_sel  input  1  ALU B operand select: 0 = rdata_B, 1 = imm.
REQ-009 SHALL have port imm  input  32  pre-extended immediate operand.
REQ-010 SHALL have port shamt  input  5  constant shift amount.
REQ-011 SHALL have port ALU_operation  input  4  operation code.
REQ-012 SHALL have ports rdata_A, rdata_B  output  32  register read data.
REQ-013 SHALL have port res  output  32  ALU result.
REQ-014 SHALL have ports zero, overflow  output  1  ALU flags.

Function
REQ-015 SHALL hold 32 registers x 32 bits; register 0 reads 0 always, writes to it ignored.
REQ-016 Reads SHALL be combinational: rdata_A = reg[reg_R_addr_A], rdata_B = reg[reg_R_addr_B].
REQ-017 Write SHALL occur at rising clk when reg_we=1 and reg_W_addr!=0; no write-to-read bypass (new value visible only after the edge).
REQ-018 Operand mux SHALL be 2:1, 32-bit, combinational: B = alu_src_sel ? imm : rdata_B; A = rdata_A always.
REQ-019 ALU SHALL be purely combinational; codes: 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR; 0101 SRL B>>shamt; 0110 SUB A-B; 0111 SLT signed (1/0); 1000 SLL B<<shamt; 1001 SRA B>>>shamt; 1010 SLLV B<<A[4:0]; 1011 SRLV; 1100 SRAV; 1101 SLTU unsigned (1/0); 1110 LUI B<<16; 1111 res=0.
REQ-020 ADD/SUB SHALL wrap modulo 2^32.
REQ-021 overflow SHALL be 1 only for ADD with same-sign operands and result sign differing, or SUB with differing-sign operands and result sign differing from A; 0 for all other codes.
REQ-022 zero SHALL be 1 iff res==32'h0, for every code.
REQ-023 SLT SHALL be correct even when A-B overflows (e.g. A=0x80000000, B=1 -> 1).
REQ-024 Shift amounts SHALL use only 5 bits; shift by 0 returns B unchanged.
REQ-025 Simultaneous write and read of same address SHALL return the old value until the edge, new value after.

Reset
REQ-026 rst=1 SHALL clear all 32 registers to 0 immediately, independent of clk; writes are blocked while rst=1.
REQ-027 ALU/mux outputs have no state; after reset, rdata_A/B=0, so with alu_src_sel=0 and ADD, res=0, zero=1, overflow=0.
REQ-028 Reset asserted mid-operation SHALL discard any pending write in that cycle.

Verification
REQ-029 Write 0x12345678 to r5, read A=5 -> 0x12345678; write 0xFFFFFFFF to r0, read A=0 -> 0.
REQ-030 r1=0x7FFFFFFF, r2=1, ADD sel=0 -> res=0x80000000, overflow=1, zero=0; SUB r2-r2 -> res=0, zero=1, overflow=0.
REQ-031 r1=0x80000000, imm=1, sel=1: SLT -> 1; SLTU -> 0; SUB -> 0x7FFFFFFF, overflow=1.
REQ-032 r2=0x80000010, shamt=4: SRL -> 0x08000001; SRA -> 0xF8000001; SLL -> 0x00000100; imm=0x0000ABCD, LUI, sel=1 -> 0xABCD0000.
REQ-033 Load r3..r31 with nonzero, pulse rst between clk edges -> all reads 0 immediately; write during rst with reg_we=1 -> ignored.
REQ-034 Same-cycle write r7=0xA5A5A5A5 with read A=7 -> old value before edge, 0xA5A5A5A5 after.
